pm_requester: RTL and testbench

Initiator-side controller for the elliptic-curve point multiplier on the 7-bit binary field. It accepts multiplication jobs from a host over a valid/ready request channel and drives the multiplier's point/scalar/start inputs. It captures the result on the multiplier's `done` pulse and returns it over a valid/ready response channel. It sits between the system bus logic and `PointMultiplier`, so the host never handles the multiplier's single-cycle start/done protocol directly.

---
 rtl/pm_requester_if.sv | 30 +++
 rtl/pm_requester.sv | 97 +++++++++
 tb/tb_pm_requester.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pm_requester_if.sv
// Request/response and multiplier-side bus for pm_requester.
// master = host plus multiplier environment, slave = the requester itself.
interface pm_requester_if #(
  parameter int PW = 14,
  parameter int SW = 7
);
  logic          req_valid;
  logic          req_ready;
  logic [PW-1:0] req_point;
  logic [SW-1:0] req_scalar;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [PW-1:0] rsp_point;
  logic          rsp_error;
  logic [PW-1:0] pm_point;
  logic [SW-1:0] pm_scalar;
  logic          pm_start;
  logic [PW-1:0] pm_result;
  logic          pm_done;

  modport master (
    output req_valid, req_point, req_scalar, rsp_ready, pm_result, pm_done,
    input  req_ready, rsp_valid, rsp_point, rsp_error, pm_point, pm_scalar, pm_start
  );

  modport slave (
    input  req_valid, req_point, req_scalar, rsp_ready, pm_result, pm_done,
    output req_ready, rsp_valid, rsp_point, rsp_error, pm_point, pm_scalar, pm_start
  );
endinterface

// File: rtl/pm_requester.sv
// Initiator-side controller wrapping the point multiplier start/done protocol in valid/ready channels.
// Optional wait timeout is enabled by defining PM_TIMEOUT_EN.
module pm_requester #(
  parameter int PW      = 14,
  parameter int SW      = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  pm_requester_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic   timeout_hit;
  logic   accept;
  logic   zero_scalar;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("pm_requester: TIMEOUT must be at least 1");
  end

  assign accept      = (state == IDLE) && bus.req_valid;
  assign zero_scalar = (bus.req_scalar == {SW{1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = zero_scalar ? RESP : LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (bus.pm_done || timeout_hit) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is a flop fed from the next state, so nothing is combinational from inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.pm_start  <= 1'b0;
      bus.pm_point  <= {PW{1'b0}};
      bus.pm_scalar <= {SW{1'b0}};
      bus.rsp_point <= {PW{1'b0}};
    end else begin
      bus.req_ready <= (state_nxt == IDLE);
      bus.rsp_valid <= (state_nxt == RESP);
      bus.pm_start  <= (state_nxt == LAUNCH);
      if (accept) begin
        bus.pm_point  <= bus.req_point;
        bus.pm_scalar <= bus.req_scalar;
        if (zero_scalar) bus.rsp_point <= {PW{1'b0}};
      end
      if (state == WAIT) begin
        if (bus.pm_done)      bus.rsp_point <= bus.pm_result;
        else if (timeout_hit) bus.rsp_point <= {PW{1'b0}};
      end
    end
  end

`ifdef PM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // Counter is zero on WAIT entry; hitting TIMEOUT-1 here means TIMEOUT WAIT cycles have elapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wait_cnt <= {CW{1'b0}};
    else if (state != WAIT)  wait_cnt <= {CW{1'b0}};
    else                     wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_error <= 1'b0;
    end else if (accept) begin
      bus.rsp_error <= 1'b0;
    end else if (state == WAIT) begin
      if (bus.pm_done)      bus.rsp_error <= 1'b0;
      else if (timeout_hit) bus.rsp_error <= 1'b1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_pm_requester.sv
// Directed bench for pm_requester: the bench plays both host and multiplier stub.
module tb_pm_requester;

`ifdef PM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pm_requester_if #(.PW(14), .SW(7)) bus ();

  pm_requester #(.PW(14), .SW(7), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_point  = '0;
    bus.req_scalar = '0;
    bus.rsp_ready  = 1'b0;
    bus.pm_result  = '0;
    bus.pm_done    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_point", 32'(bus.rsp_point), 32'd0);
    chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    chk("rst_pm_start",  32'(bus.pm_start),  32'd0);
    chk("rst_pm_point",  32'(bus.pm_point),  32'd0);
    chk("rst_pm_scalar", 32'(bus.pm_scalar), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic job, scalar 3, done 40 cycles after start
    bus.req_valid  = 1'b1;
    bus.req_point  = 14'b11101111000001;
    bus.req_scalar = 7'd3;
    tick();
    chk("basic_start",     32'(bus.pm_start),  32'd1);
    chk("basic_req_ready", 32'(bus.req_ready), 32'd0);
    chk("basic_pm_point",  32'(bus.pm_point),  32'h3BC1);
    chk("basic_pm_scalar", 32'(bus.pm_scalar), 32'd3);
    bus.req_valid  = 1'b0;
    bus.req_point  = '0;
    bus.req_scalar = '0;
    tick();
    chk("basic_start_pulse", 32'(bus.pm_start), 32'd0);
    for (int i = 0; i < 38; i++) begin
      tick();
      chk("basic_wait_point",  32'(bus.pm_point),  32'h3BC1);
      chk("basic_wait_scalar", 32'(bus.pm_scalar), 32'd3);
      chk("basic_wait_valid",  32'(bus.rsp_valid), 32'd0);
      chk("basic_wait_start",  32'(bus.pm_start),  32'd0);
    end
    bus.pm_done   = 1'b1;
    bus.pm_result = 14'h1A5C;
    tick();
    bus.pm_done   = 1'b0;
    bus.pm_result = '0;
    chk("basic_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("basic_rsp_point", 32'(bus.rsp_point), 32'h1A5C);
    chk("basic_rsp_error", 32'(bus.rsp_error), 32'd0);

    // Backpressure: a competing request must not be taken while RESP stalls
    bus.req_valid  = 1'b1;
    bus.req_point  = 14'h0555;
    bus.req_scalar = 7'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_point", 32'(bus.rsp_point), 32'h1A5C);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_pm_scalar", 32'(bus.pm_scalar), 32'd3);
      chk("bp_pm_start",  32'(bus.pm_start),  32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;

    // Zero scalar: answer directly with the point at infinity
    bus.req_valid  = 1'b1;
    bus.req_point  = 14'h1234;
    bus.req_scalar = 7'd0;
    tick();
    bus.req_valid = 1'b0;
    chk("zero_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("zero_rsp_point", 32'(bus.rsp_point), 32'd0);
    chk("zero_rsp_error", 32'(bus.rsp_error), 32'd0);
    chk("zero_no_start",  32'(bus.pm_start),  32'd0);
    chk("zero_req_ready", 32'(bus.req_ready), 32'd0);
    chk("zero_pm_point",  32'(bus.pm_point),  32'h1234);
    bus.rsp_ready = 1'b1;
    tick();
    chk("zero_done_ready", 32'(bus.req_ready), 32'd1);
    chk("zero_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("zero_done_start", 32'(bus.pm_start),  32'd0);

    // Stale done in IDLE
    bus.pm_done   = 1'b1;
    bus.pm_result = 14'h0777;
    tick();
    bus.pm_done = 1'b0;
    chk("idle_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("idle_done_ready", 32'(bus.req_ready), 32'd1);

    // Back-to-back jobs, scalar 5 then 7, rsp_ready held high
    bus.req_valid  = 1'b1;
    bus.req_point  = 14'h0ABC;
    bus.req_scalar = 7'd5;
    tick();
    chk("b2b1_start",  32'(bus.pm_start),  32'd1);
    chk("b2b1_scalar", 32'(bus.pm_scalar), 32'd5);
    bus.req_valid = 1'b0;
    tick();
    chk("b2b1_start_pulse", 32'(bus.pm_start), 32'd0);
    bus.pm_done   = 1'b1;
    bus.pm_result = 14'h0111;
    tick();
    bus.pm_done = 1'b0;
    chk("b2b1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b2b1_rsp_point", 32'(bus.rsp_point), 32'h0111);
    bus.req_valid  = 1'b1;
    bus.req_point  = 14'h2222;
    bus.req_scalar = 7'd7;
    tick();
    chk("b2b_idle_ready",  32'(bus.req_ready), 32'd1);
    chk("b2b_idle_valid",  32'(bus.rsp_valid), 32'd0);
    chk("b2b_idle_start",  32'(bus.pm_start),  32'd0);
    chk("b2b_idle_scalar", 32'(bus.pm_scalar), 32'd5);
    tick();
    chk("b2b2_start",  32'(bus.pm_start),  32'd1);
    chk("b2b2_scalar", 32'(bus.pm_scalar), 32'd7);
    chk("b2b2_point",  32'(bus.pm_point),  32'h2222);
    chk("b2b2_ready",  32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    bus.pm_done   = 1'b1;
    bus.pm_result = 14'h0333;
    tick();
    bus.pm_done = 1'b0;
    chk("launch_done_ignored", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("launch_done_still", 32'(bus.rsp_valid), 32'd0);
    bus.pm_done   = 1'b1;
    bus.pm_result = 14'h0222;
    tick();
    bus.pm_done = 1'b0;
    chk("b2b2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b2b2_rsp_point", 32'(bus.rsp_point), 32'h0222);
    tick();
    chk("b2b2_handshake_valid", 32'(bus.rsp_valid), 32'd0);
    chk("b2b2_handshake_ready", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b0;

    // Reset mid-WAIT: asynchronous clear, later done is ignored
    bus.req_valid  = 1'b1;
    bus.req_point  = 14'h1F0F;
    bus.req_scalar = 7'd3;
    tick();
    bus.req_valid = 1'b0;
    chk("rstjob_start", 32'(bus.pm_start), 32'd1);
    for (int i = 0; i < 20; i++) tick();
    chk("rstjob_busy", 32'(bus.req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req_ready", 32'(bus.req_ready), 32'd1);
    chk("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_pm_point",  32'(bus.pm_point),  32'd0);
    chk("async_pm_scalar", 32'(bus.pm_scalar), 32'd0);
    chk("async_pm_start",  32'(bus.pm_start),  32'd0);
    chk("async_rsp_point", 32'(bus.rsp_point), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.pm_done   = 1'b1;
    bus.pm_result = 14'h1111;
    tick();
    bus.pm_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rst_point", 32'(bus.rsp_point), 32'd0);
      tick();
    end

`ifdef PM_TIMEOUT_EN
    // Timeout after 16 WAIT cycles with no done
    bus.req_valid  = 1'b1;
    bus.req_point  = 14'h0F0F;
    bus.req_scalar = 7'd2;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_waiting", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to_rsp_error", 32'(bus.rsp_error), 32'd1);
    chk("to_rsp_point", 32'(bus.rsp_point), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("to_handshake", 32'(bus.rsp_valid), 32'd0);
    bus.pm_done   = 1'b1;
    bus.pm_result = 14'h0AAA;
    tick();
    bus.pm_done = 1'b0;
    tick();
    chk("to_late_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("to_late_done_ready", 32'(bus.req_ready), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
